// File: rtl/hawkes_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hawkes_fixed_pkg
//  Description : Fixed-point formats and logarithm constants shared by the
//                Hawkes datapath (ln unit, exponential unit).
//  Revision    : 1.0 - initial release
// ============================================================================
package hawkes_fixed_pkg;

   // Operand / result formats: unsigned Q2.8 in, signed Q4.8 out
   localparam int         Q28_W      = 10;
   localparam int         Q48_W      = 12;
   localparam int         Q_FRAC     = 8;
   localparam logic [9:0] NUMBER_ONE = 10'h100;

   // Master precision of the stored constants (Q0.20); consumers round down
   // to their own fraction width, which must not exceed TAB_FRAC.
   localparam int          TAB_FRAC = 20;
   localparam logic [19:0] LN2_Q20  = 20'd726817;

   // ln(1 + 2^-k) for k = 1..10 in Q0.20
   function automatic logic [19:0] ln_tab_q20(input logic [3:0] k);
      logic [19:0] v;
      case (k)
         4'd1:    v = 20'd425161;
         4'd2:    v = 20'd233983;
         4'd3:    v = 20'd123504;
         4'd4:    v = 20'd63570;
         4'd5:    v = 20'd32266;
         4'd6:    v = 20'd16257;
         4'd7:    v = 20'd8160;
         4'd8:    v = 20'd4088;
         4'd9:    v = 20'd2046;
         4'd10:   v = 20'd1024;
         default: v = 20'd0;
      endcase
      return v;
   endfunction

   // Round a Q0.20 constant to 'frac' fraction bits (round half up)
   function automatic logic [19:0] round_q20(input logic [19:0] c, input int frac);
      logic [20:0] s;
      if (frac >= TAB_FRAC) begin
         return c;
      end
      s = {1'b0, c} + (21'd1 << (TAB_FRAC - frac - 1));
      return s[20:1] >> (TAB_FRAC - frac - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ln_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ln_unit_if
//  Description : start/done handshake and data bus of the ln unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ln_unit_if;
   import hawkes_fixed_pkg::*;

   logic             start;
   logic [Q28_W-1:0] x0;
   logic [Q48_W-1:0] y;
   logic             done;
   logic             busy;
   logic             err;

   modport master (output start, x0, input  y, done, busy, err);
   modport slave  (input  start, x0, output y, done, busy, err);
endinterface
`default_nettype wire

// File: rtl/ln_lut.sv
`default_nettype none
// ============================================================================
//  Module      : ln_lut
//  Description : Combinational ROM k -> ln(1 + 2^-k), FRAC fraction bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module ln_lut
   import hawkes_fixed_pkg::*;
#(
   parameter int FRAC = 12
) (
   input  wire logic [3:0]      i_k,
   output logic      [FRAC-1:0] o_ln
);

   // Table lookup rounded from the master Q0.20 constants
   always_comb begin
      o_ln = FRAC'(round_q20(ln_tab_q20(i_k), FRAC));
   end

endmodule
`default_nettype wire

// File: rtl/ln_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ln_unit
//  Description : Iterative natural logarithm, y = ln(x0), Q2.8 in, Q4.8 out.
//                Leading-one normalisation to m in [0.5,1), then greedy
//                multiplicative normalisation m*(1+2^-k) -> 1, one k/cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ln_unit
   import hawkes_fixed_pkg::*;
#(
   parameter int N_ITER = 8,   // 4..10
   parameter int GUARD  = 4    // 2..12
) (
   input  wire logic clk,
   input  wire logic rst,
   ln_unit_if.slave  bus
);

   localparam int c_F  = Q_FRAC + GUARD;   // internal fraction bits
   localparam int c_MW = c_F + 1;          // m and t: 1 integer bit
   localparam int c_AW = 4 + c_F;          // acc: signed 4.c_F

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_NORM = 2'd1;
   localparam logic [1:0] c_S_ITER = 2'd2;
   localparam logic [1:0] c_S_FIN  = 2'd3;

   localparam logic [3:0]             c_KLAST = 4'(N_ITER);
   localparam logic [c_MW-1:0]        c_ONE   = {1'b1, {c_F{1'b0}}};
   localparam logic signed [c_AW-1:0] c_LN2   = c_AW'(round_q20(LN2_Q20, c_F));
   localparam logic [Q48_W-1:0]       c_Y_ERR = 12'h800;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [Q28_W-1:0]       r_x;
   logic [c_MW-1:0]        r_m;
   logic signed [c_AW-1:0] r_acc;
   logic [3:0]             r_k;
   logic                   r_zero;
   logic [Q48_W-1:0]       r_y;
   logic                   r_done;
   logic                   r_busy;
   logic                   r_err;

   logic                   w_load;
   logic                   w_norm;
   logic                   w_iter;
   logic                   w_fin;
   logic                   w_busy_nxt;

   logic [3:0]             w_p;
   logic signed [4:0]      w_e;
   logic signed [c_AW-1:0] w_e_ext;
   logic signed [c_AW-1:0] w_acc0;
   logic [Q28_W+c_F-2:0]   w_x_wide;
   logic [c_MW-1:0]        w_m0;
   logic [c_MW-1:0]        w_t;
   logic                   w_take;
   logic [c_F-1:0]         w_lut;
   logic signed [c_AW-1:0] w_lut_ext;

   ln_lut #(
      .FRAC (c_F)
   ) u_lut (
      .i_k  (r_k),
      .o_ln (w_lut)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE -> NORM -> ITER (N_ITER cycles) -> FIN -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (bus.start) w_state_nxt = c_S_NORM;
         c_S_NORM: w_state_nxt = c_S_ITER;
         c_S_ITER: if (r_k == c_KLAST) w_state_nxt = c_S_FIN;
         c_S_FIN:  w_state_nxt = c_S_IDLE;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   // FSM output decode; busy covers the whole job including the done cycle
   always_comb begin
      w_load     = (r_state == c_S_IDLE) && bus.start;
      w_norm     = (r_state == c_S_NORM);
      w_iter     = (r_state == c_S_ITER);
      w_fin      = (r_state == c_S_FIN);
      w_busy_nxt = (w_state_nxt != c_S_IDLE) || w_fin;
   end

   // Leading-one index p and exponent e = p - 7
   always_comb begin
      w_p = 4'd0;
      for (int i = 0; i < Q28_W; i++) begin
         if (r_x[i]) w_p = 4'(i);
      end
      w_e     = $signed({1'b0, w_p}) - 5'sd7;
      w_e_ext = {{(c_AW-5){w_e[4]}}, w_e};
      w_acc0  = w_e_ext * c_LN2;
   end

   // m = x * 2^(7-p) in Q1.c_F; shifting a pre-widened x keeps every shift
   // amount non-negative whatever GUARD is
   always_comb begin
      w_x_wide = {r_x, {(c_F-1){1'b0}}};
      w_m0     = c_MW'(w_x_wide >> w_p);
   end

   // One greedy step: accept m*(1+2^-k) only while it stays <= 1.0
   always_comb begin
      w_t       = r_m + (r_m >> r_k);
      w_take    = (w_t <= c_ONE);
      w_lut_ext = $signed({4'b0000, w_lut});
   end

   // Datapath registers. A zero operand still walks the ITER cycles so the
   // latency stays fixed; its result is overridden in FIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x    <= '0;
         r_m    <= '0;
         r_acc  <= '0;
         r_k    <= '0;
         r_zero <= 1'b0;
      end else begin
         if (w_load) begin
            r_x <= bus.x0;
         end
         if (w_norm) begin
            r_m    <= w_m0;
            r_acc  <= w_acc0;
            r_k    <= 4'd1;
            r_zero <= (r_x == '0);
         end
         if (w_iter) begin
            if (w_take) begin
               r_m   <= w_t;
               r_acc <= r_acc - w_lut_ext;
            end
            r_k <= r_k + 4'd1;
         end
      end
   end

   // Registered outputs; dropping the guard bits of a two's-complement
   // value rounds toward -inf
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y    <= '0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_fin;
         r_busy <= w_busy_nxt;
         if (w_fin) begin
            r_y   <= r_zero ? c_Y_ERR : r_acc[c_AW-1:GUARD];
            r_err <= r_zero;
         end
      end
   end

   assign bus.y    = r_y;
   assign bus.done = r_done;
   assign bus.busy = r_busy;
   assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ln_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ln_unit
//  Description : Self-checking bench for ln_unit: directed vectors, handshake
//                and reset cases, and a sweep of every nonzero operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ln_unit;

   localparam int c_N_ITER = 8;
   localparam int c_LAT    = c_N_ITER + 2;

   typedef struct {
      int x;
      int y;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t e_cur;
   int   y_got;

   ln_unit_if bus ();

   ln_unit #(
      .N_ITER (c_N_ITER),
      .GUARD  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Greedy multiplicative normalisation evaluated in plain integers at 12
   // fraction bits, with the constants derived from $ln.
   function automatic exp_t model(input int x);
      exp_t   r;
      int     p;
      int     ln2;
      longint m, t, acc;
      r.x = x;
      if (x == 0) begin
         r.y   = -2048;
         r.err = 1'b1;
         return r;
      end
      p = 0;
      for (int b = 0; b < 10; b++) if (x >= (1 << b)) p = b;
      ln2 = $rtoi($ln(2.0) * 4096.0 + 0.5);
      m   = longint'(x) << (11 - p);
      acc = longint'((p - 7) * ln2);
      for (int k = 1; k <= c_N_ITER; k++) begin
         t = m + (m >> k);
         if (t <= 4096) begin
            m   = t;
            acc = acc - longint'($rtoi($ln(1.0 + 1.0 / real'(1 << k)) * 4096.0 + 0.5));
         end
      end
      r.y   = int'(acc >>> 4);
      r.err = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Compare process: every done pulse is matched against the model
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got y=%h err=%b, expected no done", bus.y, bus.err);
         end else begin
            real dev;
            e_cur = exp_q.pop_front();
            n_vec++;
            if ($signed(bus.y) != e_cur.y || bus.err != e_cur.err) begin
               n_err++;
               $display("FAIL result x0=%h: got y=%0d err=%b, expected y=%0d err=%b",
                        e_cur.x[9:0], $signed(bus.y), bus.err, e_cur.y, e_cur.err);
            end
            if (!e_cur.err) begin
               n_vec++;
               dev = real'($signed(bus.y)) / 256.0 - $ln(real'(e_cur.x) / 256.0);
               if (dev < 0.0) dev = -dev;
               if (dev > 2.0 / 256.0 + 1.0e-9) begin
                  n_err++;
                  $display("FAIL accuracy x0=%h: got y=%0d, expected within 2 LSB of %f",
                           e_cur.x[9:0], $signed(bus.y), $ln(real'(e_cur.x) / 256.0) * 256.0);
               end
            end
         end
      end
   end

   // One transaction with latency/busy checks; optional ignored start at cycle 4
   task automatic run_op(input logic [9:0] x, input bit inject, output int y_out);
      int lat;
      @(negedge clk);
      bus.x0    = x;
      bus.start = 1'b1;
      exp_q.push_back(model(int'(x)));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      for (int i = 1; i <= c_LAT + 4; i++) begin
         if (inject && i == 4) begin
            bus.x0    = 10'h080;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy !== 1'b1) chk("busy_during_op", int'(bus.busy), 1);
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      bus.start = 1'b0;
      chk("done_latency", lat, c_LAT);
      chk("busy_at_done", int'(bus.busy), 1);
      y_out = int'($signed(bus.y));
      @(posedge clk);
      #1;
      chk("busy_after_done", int'(bus.busy), 0);
      chk("done_one_cycle", int'(bus.done), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.x0    = '0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_y", int'(bus.y), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_err", int'(bus.err), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vectors with hand-computed expectations
      run_op(10'h100, 1'b0, y_got);
      chk("lit_one", y_got, 0);
      chk("lit_one_err", int'(bus.err), 0);
      run_op(10'h080, 1'b0, y_got);
      chk_rng("lit_half", y_got, -178, -176);
      run_op(10'h001, 1'b0, y_got);
      chk_rng("lit_min", y_got, -1422, -1418);
      run_op(10'h1FF, 1'b0, y_got);
      chk_rng("lit_max", y_got, 176, 178);
      run_op(10'h000, 1'b0, y_got);
      chk("lit_zero_y", y_got, -2048);
      chk("lit_zero_err", int'(bus.err), 1);

      // Start pulsed mid-operation is ignored
      run_op(10'h100, 1'b1, y_got);
      chk("ignored_start_y", y_got, 0);
      repeat (c_LAT + 2) @(negedge clk);
      chk("ignored_start_idle", int'(bus.busy), 0);

      // Reset at cycle 5 aborts the job with no done
      run_op(10'h080, 1'b0, y_got);
      @(negedge clk);
      bus.x0    = 10'h1FF;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_y", int'(bus.y), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_err", int'(bus.err), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (c_LAT + 3) @(negedge clk);
      chk("abort_no_busy", int'(bus.busy), 0);
      run_op(10'h1FF, 1'b0, y_got);
      chk_rng("after_abort", y_got, 176, 178);

      // Sweep of every nonzero operand
      for (int x = 1; x < 1024; x++) begin
         run_op(10'(x), 1'b0, y_got);
      end

      @(negedge clk);
      chk("pending_results", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
